req_sched: RTL and testbench

Round-robin scheduler that shares one single-owner resource among N requesters. Each requester gets exclusive access until it signals `done`, drops its request, or hits a hold timeout. It sits between the requesting always-block controllers and the shared datapath register. It drives a one-hot grant plus an encoded owner index that the datapath mux uses.

---
 rtl/req_sched.sv | 96 +++++++++
 tb/tb_req_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/req_sched.sv
// Round-robin owner scheduler: one requester at a time holds the shared resource
// until done, request drop or hold timeout; priority rotates past the last owner.
module req_sched #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic          sel_found;
  logic [OW-1:0] sel_idx;
  logic [OW-1:0] next_ptr;
  int unsigned   cand;

  // First pending requester at or above ptr, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!sel_found && req[OW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = OW'(cand);
      end
    end
  end

  always_comb begin
    next_ptr = '0;
    if (owner != OW'(N - 1)) next_ptr = owner + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant    <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
            owner    <= sel_idx;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Voluntary release outranks the hold limit, so done on the last cycle is not a timeout.
          if (done[owner] || !req[owner]) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= RELEASE;
          end else if (hold_cnt == HW'(MAX_HOLD)) begin
            grant   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          timeout <= 1'b0;
          ptr     <= next_ptr;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_sched.sv
// Self-checking bench for req_sched: fixed vectors, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_req_sched;

  localparam int N  = 4;
  localparam int MH = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, done, grant;
  logic [1:0] owner;
  logic       busy, timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  req_sched #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .owner(owner), .busy(busy), .timeout(timeout)
  );

  // Reference model: who holds the resource, for how long, and the dead time left.
  bit m_active, m_to;
  int m_own, m_held, m_gap, m_last;

  function automatic void model_reset();
    m_active = 0; m_to = 0; m_own = 0; m_held = 0; m_gap = 0; m_last = N - 1;
  endfunction

  function automatic void model_step(logic [3:0] r, logic [3:0] d);
    if (m_active) begin
      if (d[m_own] || !r[m_own]) begin
        m_active = 0; m_to = 0; m_gap = 1;
      end else if (m_held == MH) begin
        m_active = 0; m_to = 1; m_gap = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--; m_to = 0; m_last = m_own;
    end else begin
      m_to = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (r[c]) begin
          m_active = 1; m_own = c; m_held = 1;
          break;
        end
      end
    end
  endfunction

  function automatic void chk(string nm, int act, int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endfunction

  function automatic void chk_model(string nm);
    chk({nm, ".grant"},   int'(grant),   m_active ? (1 << m_own) : 0);
    chk({nm, ".owner"},   int'(owner),   m_own);
    chk({nm, ".busy"},    int'(busy),    int'(m_active));
    chk({nm, ".timeout"}, int'(timeout), int'(m_to));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(req, done);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst.grant", int'(grant), 0);
    chk("rst.owner", int'(owner), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] g;
    int         own;
    logic       b;
    logic       to;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int hi, held, gap, n_gr;
    int exp_seq[5];

    rst_n = 1'b0; req = '0; done = '0;

    // Single requester, ignored foreign done, owner request drop, pointer after drop.
    tbl[0]  = '{4'b0100, 4'b0000, 4'b0100, 2, 1'b1, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 2, 1'b1, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0000, 2, 1'b0, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 2, 1'b0, 1'b0};
    tbl[4]  = '{4'b0110, 4'b0000, 4'b0010, 1, 1'b1, 1'b0};
    tbl[5]  = '{4'b0110, 4'b1000, 4'b0010, 1, 1'b1, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0000, 4'b0000, 1, 1'b0, 1'b0};
    tbl[7]  = '{4'b0110, 4'b0000, 4'b0000, 1, 1'b0, 1'b0};
    tbl[8]  = '{4'b0110, 4'b0000, 4'b0100, 2, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 2, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 2, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req; done = tbl[i].done;
      tick();
      chk($sformatf("vec%0d.grant", i), int'(grant), int'(tbl[i].g));
      chk($sformatf("vec%0d.owner", i), int'(owner), tbl[i].own);
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].b));
      chk($sformatf("vec%0d.timeout", i), int'(timeout), int'(tbl[i].to));
    end
    done = '0;

    // Reset asserted mid-grant takes effect immediately.
    do_reset();
    req = 4'b0010;
    tick();
    chk("rmid.pre_grant", int'(grant), 2);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rmid.grant", int'(grant), 0);
    chk("rmid.busy", int'(busy), 0);
    chk("rmid.owner", int'(owner), 0);
    chk("rmid.timeout", int'(timeout), 0);
    req = 4'b1010;
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rmid.after_grant", int'(grant), 2);
    chk("rmid.after_owner", int'(owner), 1);

    // Hold timeout, then rotation to the other pending requester.
    do_reset();
    req = 4'b1010;
    tick();
    hi = 0;
    for (int c = 0; c < 40 && grant == 4'b0010; c++) begin
      hi++;
      tick();
    end
    chk("to.hold_cycles", hi, MH);
    chk("to.pulse", int'(timeout), 1);
    chk("to.busy", int'(busy), 0);
    tick();
    chk("to.pulse_end", int'(timeout), 0);
    chk("to.dead_grant", int'(grant), 0);
    tick();
    chk("to.next_grant", int'(grant), 8);
    chk("to.next_owner", int'(owner), 3);

    // done on the last allowed cycle is a normal release.
    do_reset();
    req = 4'b0010;
    tick();
    repeat (MH - 1) tick();
    chk("bnd.still_granted", int'(grant), 2);
    done = 4'b0010;
    tick();
    done = '0;
    chk("bnd.grant", int'(grant), 0);
    chk("bnd.timeout", int'(timeout), 0);
    tick();
    chk("bnd.timeout_next", int'(timeout), 0);

    // Rotation with all requesting; owner releases on its second grant cycle.
    do_reset();
    req = 4'b1111;
    exp_seq = '{1, 2, 4, 8, 1};
    held = 0; gap = 0; n_gr = 0;
    for (int c = 0; c < 60 && n_gr < 5; c++) begin
      tick();
      if (grant != 0) begin
        held++;
        if (held == 1) begin
          chk($sformatf("rot%0d.grant", n_gr), int'(grant), exp_seq[n_gr]);
          if (n_gr > 0) chk($sformatf("rot%0d.gap", n_gr), gap, 2);
          n_gr++;
        end
      end else begin
        if (held > 0) gap = 0;
        held = 0;
        gap++;
      end
      done = (grant != 0 && held == 2) ? grant : 4'b0000;
    end
    chk("rot.count", n_gr, 5);
    done = '0;

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      done = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      tick();
      chk_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
